width_gearbox: RTL and testbench



---
 rtl/width_gearbox_pkg.sv | 27 ++
 rtl/gearbox_buf.sv | 99 +++++++++
 rtl/width_gearbox.sv | 135 +++++++++++++
 tb/tb_width_gearbox.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/width_gearbox_pkg.sv
// -----------------------------------------------------------------------------
// width_gearbox_pkg
// Shared helpers for the width_gearbox streaming width converter:
//   gb_buf_w     - bit capacity of the internal buffer for a given IN_W/OUT_W
//   gb_cnt_w     - counter width able to hold the values 0..bits
//   gb_params_ok - legality check on the width parameters (both >= 1)
// No ports (package).
// -----------------------------------------------------------------------------
package width_gearbox_pkg;

   // Two input words plus two output words of headroom lets a push and a pop
   // happen every cycle without in_ready ever dropping while out_ready is high.
   function automatic int gb_buf_w(input int in_w, input int out_w);
      return 2 * (in_w + out_w);
   endfunction

   // Number of bits needed to represent every value from 0 up to 'bits'.
   function automatic int gb_cnt_w(input int bits);
      return $clog2(bits + 1);
   endfunction

   // Both stream widths must be at least one bit.
   function automatic bit gb_params_ok(input int in_w, input int out_w);
      return (in_w >= 1) && (out_w >= 1);
   endfunction

endpackage : width_gearbox_pkg

// File: rtl/gearbox_buf.sv
// -----------------------------------------------------------------------------
// gearbox_buf
// Left-aligned shift/insert bit buffer with occupancy counter. The oldest bit
// sits at BUF_W-1; a pop shifts left by OUT_W with zero fill, a push ORs the
// input word in directly behind the last valid bit (after any same-cycle pop).
// Bits beyond the count are kept at zero, which is what makes the OR insert
// and the zero padding of a rounded-up count work.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   i_clr       synchronous clear, overrides push and pop
//   i_push      write i_data this cycle
//   i_pop       remove OUT_W bits from the head this cycle
//   i_round     with i_push: round the new count up to a multiple of OUT_W
//   i_data      IN_W-bit input word, MSB first
//   o_top       the OUT_W oldest buffer bits
//   o_cnt       number of valid bits in the buffer
// -----------------------------------------------------------------------------
module gearbox_buf #(
   parameter int IN_W     = 24,
   parameter int OUT_W    = 128,
   parameter int BUF_W    = 304,
   parameter int CW       = 9,
   parameter bit ROUND_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_round,
   input  logic [IN_W-1:0]  i_data,
   output logic [OUT_W-1:0] o_top,
   output logic [CW-1:0]    o_cnt
);

   localparam logic [CW-1:0] OUT_C = CW'(OUT_W);
   localparam logic [CW-1:0] IN_C  = CW'(IN_W);

   logic [BUF_W-1:0] r_buf;
   logic [BUF_W-1:0] w_buf_pop;
   logic [BUF_W-1:0] w_ins;
   logic [BUF_W-1:0] w_buf_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_pop;
   logic [CW-1:0]    w_cnt_push;
   logic [CW-1:0]    w_cnt_rnd;
   logic [CW-1:0]    w_cnt_nxt;

   // Next buffer/count: pop first, then push at the post-pop fill level.
   always_comb begin
      w_buf_pop  = r_buf;
      w_cnt_pop  = r_cnt;
      if (i_pop) begin
         w_buf_pop = r_buf << OUT_W;
         w_cnt_pop = r_cnt - OUT_C;
      end else begin
         w_buf_pop = r_buf;
         w_cnt_pop = r_cnt;
      end

      // Input word left-aligned, then moved down behind the valid bits.
      w_ins      = {i_data, {(BUF_W-IN_W){1'b0}}} >> w_cnt_pop;
      w_cnt_push = w_cnt_pop + IN_C;
      // Padding bits need no write: everything past the count is already 0.
      w_cnt_rnd  = ((w_cnt_push + OUT_C - CW'(1)) / OUT_C) * OUT_C;

      w_buf_nxt  = w_buf_pop;
      w_cnt_nxt  = w_cnt_pop;
      if (i_clr) begin
         w_buf_nxt = '0;
         w_cnt_nxt = '0;
      end else if (i_push) begin
         w_buf_nxt = w_buf_pop | w_ins;
         if (ROUND_EN && i_round) begin
            w_cnt_nxt = w_cnt_rnd;
         end else begin
            w_cnt_nxt = w_cnt_push;
         end
      end else begin
         w_buf_nxt = w_buf_pop;
         w_cnt_nxt = w_cnt_pop;
      end
   end

   // Buffer and count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else begin
         r_buf <= w_buf_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_top = r_buf[BUF_W-1 -: OUT_W];
   assign o_cnt = r_cnt;

endmodule : gearbox_buf

// File: rtl/width_gearbox.sv
// -----------------------------------------------------------------------------
// width_gearbox
// Streaming width converter IN_W -> OUT_W (any ratio, up or down) with
// valid/ready on both sides. Bits are packed MSB first: earlier input bits land
// in more-significant output bits. All outputs are decoded from registers, so
// there is no combinational path from out_ready to in_ready.
// Optional feature macro: WIDTH_GEARBOX_LAST_EN adds frame-end handling
// (in_last pads the frame up to a whole output word, out_last marks it).
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   clr        synchronous clear, discards all buffered bits
//   in_valid   input word valid
//   in_ready   input word accepted this cycle
//   in_data    IN_W-bit input word, bit IN_W-1 first in the stream
//   in_last    (WIDTH_GEARBOX_LAST_EN) pushed word ends a frame
//   out_valid  output word valid
//   out_ready  downstream accepts the output word
//   out_data   OUT_W-bit output word, bit OUT_W-1 earliest
//   out_last   (WIDTH_GEARBOX_LAST_EN) output word carries the frame's end
//   level      number of valid bits in the buffer
// -----------------------------------------------------------------------------
module width_gearbox
   import width_gearbox_pkg::*;
#(
   parameter  int IN_W  = 24,
   parameter  int OUT_W = 128,
   localparam int BUF_W = gb_buf_w(IN_W, OUT_W),
   localparam int CNT_W = gb_cnt_w(BUF_W)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
`ifdef WIDTH_GEARBOX_LAST_EN
   input  logic             in_last,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
`ifdef WIDTH_GEARBOX_LAST_EN
   output logic             out_last,
`endif
   output logic [CNT_W-1:0] level
);

   if (!gb_params_ok(IN_W, OUT_W)) begin : g_bad_params
      $error("width_gearbox: IN_W and OUT_W must both be >= 1");
   end

`ifdef WIDTH_GEARBOX_LAST_EN
   // A rounded-up frame end can count past BUF_W, so the internal counter
   // gets room for one extra output word.
   localparam int CW       = gb_cnt_w(BUF_W + OUT_W);
   localparam bit ROUND_EN = 1'b1;
`else
   localparam int CW       = CNT_W;
   localparam bit ROUND_EN = 1'b0;
`endif

   logic [CW-1:0]    w_cnt;
   logic [OUT_W-1:0] w_top;
   logic             w_room;
   logic             w_push;
   logic             w_pop;
   logic             w_round;

   assign w_room    = (int'(w_cnt) + IN_W) <= BUF_W;
   assign out_valid = int'(w_cnt) >= OUT_W;
   assign out_data  = w_top;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

`ifdef WIDTH_GEARBOX_LAST_EN
   localparam int LVL_MAX = (1 << CNT_W) - 1;

   logic r_pend;
   logic w_pend_nxt;

   // While a frame end is pending the count is a whole number of output
   // words and no pushes occur, so the last word is the one at count OUT_W.
   assign in_ready = w_room & ~r_pend;
   assign out_last = r_pend & (w_cnt == CW'(OUT_W));
   assign w_round  = in_last;
   assign level    = (int'(w_cnt) > LVL_MAX) ? CNT_W'(LVL_MAX) : w_cnt[CNT_W-1:0];

   // Frame-end pending flag: set by a last push, cleared when its word pops.
   always_comb begin
      w_pend_nxt = r_pend;
      if (clr) begin
         w_pend_nxt = 1'b0;
      end else if (w_push & in_last) begin
         w_pend_nxt = 1'b1;
      end else if (w_pop & out_last) begin
         w_pend_nxt = 1'b0;
      end else begin
         w_pend_nxt = r_pend;
      end
   end

   // Pending flag register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end
`else
   assign in_ready = w_room;
   assign w_round  = 1'b0;
   assign level    = w_cnt;
`endif

   gearbox_buf #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .BUF_W    (BUF_W),
      .CW       (CW),
      .ROUND_EN (ROUND_EN)
   ) u_buf (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (clr),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_round (w_round),
      .i_data  (in_data),
      .o_top   (w_top),
      .o_cnt   (w_cnt)
   );

endmodule : width_gearbox

// File: tb/tb_width_gearbox.sv
// -----------------------------------------------------------------------------
// tb_width_gearbox
// Directed bench for width_gearbox: a 24->128 upsizer and a 128->24 downsizer
// share one clock and reset. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge. Build with WIDTH_GEARBOX_LAST_EN to
// include the frame-end test.
// -----------------------------------------------------------------------------
module tb_width_gearbox;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // Upsizer 24 -> 128
   logic         up_clr, up_in_valid, up_in_ready, up_out_valid, up_out_ready;
   logic [23:0]  up_in_data;
   logic [127:0] up_out_data;
   logic [8:0]   up_level;
   // Downsizer 128 -> 24
   logic         dn_clr, dn_in_valid, dn_in_ready, dn_out_valid, dn_out_ready;
   logic [127:0] dn_in_data;
   logic [23:0]  dn_out_data;
   logic [8:0]   dn_level;
`ifdef WIDTH_GEARBOX_LAST_EN
   logic         up_in_last, up_out_last, dn_in_last, dn_out_last;
`endif

   width_gearbox #(.IN_W(24), .OUT_W(128)) u_up (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (up_clr),
      .in_valid  (up_in_valid),
      .in_ready  (up_in_ready),
      .in_data   (up_in_data),
`ifdef WIDTH_GEARBOX_LAST_EN
      .in_last   (up_in_last),
`endif
      .out_valid (up_out_valid),
      .out_ready (up_out_ready),
      .out_data  (up_out_data),
`ifdef WIDTH_GEARBOX_LAST_EN
      .out_last  (up_out_last),
`endif
      .level     (up_level)
   );

   width_gearbox #(.IN_W(128), .OUT_W(24)) u_dn (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (dn_clr),
      .in_valid  (dn_in_valid),
      .in_ready  (dn_in_ready),
      .in_data   (dn_in_data),
`ifdef WIDTH_GEARBOX_LAST_EN
      .in_last   (dn_in_last),
`endif
      .out_valid (dn_out_valid),
      .out_ready (dn_out_ready),
      .out_data  (dn_out_data),
`ifdef WIDTH_GEARBOX_LAST_EN
      .out_last  (dn_out_last),
`endif
      .level     (dn_level)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int up_waits = 0;

   logic [127:0] up_q[$];
   logic [23:0]  dn_q[$];
   logic         dn_lq[$];

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Record every output word that is really popped on the coming edge.
   always @(negedge clk) begin
      if (rstn && !up_clr && up_out_valid && up_out_ready) up_q.push_back(up_out_data);
      if (rstn && !dn_clr && dn_out_valid && dn_out_ready) begin
         dn_q.push_back(dn_out_data);
`ifdef WIDTH_GEARBOX_LAST_EN
         dn_lq.push_back(dn_out_last);
`endif
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic up_send(input logic [23:0] d);
      int n;
      n = 0;
      up_in_valid = 1'b1;
      up_in_data  = d;
      @(negedge clk);
      while (!up_in_ready && n < 50) begin
         n++;
         up_waits++;
         @(negedge clk);
      end
      if (n >= 50) check_val("up_send_timeout", 128'(0), 128'(1));
      @(posedge clk);
      #1;
      up_in_valid = 1'b0;
      up_in_data  = '0;
   endtask

   task automatic dn_send(input logic [127:0] d);
      int n;
      n = 0;
      dn_in_valid = 1'b1;
      dn_in_data  = d;
      @(negedge clk);
      while (!dn_in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) check_val("dn_send_timeout", 128'(0), 128'(1));
      @(posedge clk);
      #1;
      dn_in_valid = 1'b0;
      dn_in_data  = '0;
   endtask

   logic [127:0] t1_exp [3] = '{128'h00000100000200000300000400000500,
                                128'h000600000700000800000900000A0000,
                                128'h0B00000C00000D00000E00000F000010};
   logic [23:0]  t2_exp [6] = '{24'h012345, 24'h6789AB, 24'hCDEFFE,
                                24'hDCBA98, 24'h765432, 24'h100000};
   logic [127:0] t4_exp [2] = '{128'h00010000010100010200010300010400,
                                128'h01050001060001070001080001090001};

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n_acc;
      rstn = 1'b0;
      up_clr = 1'b0; up_in_valid = 1'b0; up_in_data = '0; up_out_ready = 1'b1;
      dn_clr = 1'b0; dn_in_valid = 1'b0; dn_in_data = '0; dn_out_ready = 1'b1;
`ifdef WIDTH_GEARBOX_LAST_EN
      up_in_last = 1'b0; dn_in_last = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check_val("rst_up_level", 128'(up_level), 128'(0));
      check_val("rst_up_valid", 128'(up_out_valid), 128'(0));
      check_val("rst_up_ready", 128'(up_in_ready), 128'(1));
      check_val("rst_up_data", up_out_data, 128'(0));
      check_val("rst_dn_level", 128'(dn_level), 128'(0));

      // Test 1: upsize 16 words back to back
      up_waits = 0;
      for (int i = 1; i <= 16; i++) up_send(24'(i));
      idle(3);
      check_val("t1_count", 128'(up_q.size()), 128'(3));
      for (int k = 0; k < 3; k++)
         check_val($sformatf("t1_w%0d", k), (k < up_q.size()) ? up_q[k] : '0, t1_exp[k]);
      check_val("t1_no_stall", 128'(up_waits), 128'(0));
      check_val("t1_level", 128'(up_level), 128'(0));

      // Test 2: downsize one word, 8-bit residue stays
      dn_send(128'h0123456789ABCDEFFEDCBA9876543210);
      idle(8);
      check_val("t2_count", 128'(dn_q.size()), 128'(5));
      for (int k = 0; k < 5; k++)
         check_val($sformatf("t2_w%0d", k), 128'((k < dn_q.size()) ? dn_q[k] : 24'h0), 128'(t2_exp[k]));
      check_val("t2_level", 128'(dn_level), 128'(8));
      check_val("t2_valid", 128'(dn_out_valid), 128'(0));

`ifdef WIDTH_GEARBOX_LAST_EN
      // Test 3: frame end pads the residue into a sixth word
      dn_clr = 1'b1;
      @(posedge clk); #1;
      dn_clr = 1'b0;
      check_val("t3_clr_level", 128'(dn_level), 128'(0));
      dn_q.delete();
      dn_lq.delete();
      dn_in_last = 1'b1;
      dn_send(128'h0123456789ABCDEFFEDCBA9876543210);
      dn_in_last = 1'b0;
      check_val("t3_ready_blocked", 128'(dn_in_ready), 128'(0));
      idle(10);
      check_val("t3_count", 128'(dn_q.size()), 128'(6));
      for (int k = 0; k < 6; k++) begin
         check_val($sformatf("t3_w%0d", k), 128'((k < dn_q.size()) ? dn_q[k] : 24'h0), 128'(t2_exp[k]));
         check_val($sformatf("t3_last%0d", k), 128'((k < dn_lq.size()) ? dn_lq[k] : 1'b0),
                   128'((k == 5) ? 1'b1 : 1'b0));
      end
      check_val("t3_level", 128'(dn_level), 128'(0));
      check_val("t3_ready_back", 128'(dn_in_ready), 128'(1));
`endif

      // Test 4: backpressure on the upsizer
      up_q.delete();
      up_out_ready = 1'b0;
      up_in_valid  = 1'b1;
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
         up_in_data = 24'h000100 + 24'(n_acc);
         @(negedge clk);
         if (up_in_ready) n_acc++;
         if (c == 10) check_val("t4_hold_mid", up_out_data, t4_exp[0]);
         @(posedge clk); #1;
      end
      up_in_valid = 1'b0;
      up_in_data  = '0;
      check_val("t4_pushes", 128'(n_acc), 128'(12));
      check_val("t4_level", 128'(up_level), 128'(288));
      check_val("t4_ready_low", 128'(up_in_ready), 128'(0));
      check_val("t4_valid", 128'(up_out_valid), 128'(1));
      check_val("t4_hold_end", up_out_data, t4_exp[0]);
      up_out_ready = 1'b1;
      idle(4);
      check_val("t4_count", 128'(up_q.size()), 128'(2));
      for (int k = 0; k < 2; k++)
         check_val($sformatf("t4_w%0d", k), (k < up_q.size()) ? up_q[k] : '0, t4_exp[k]);
      check_val("t4_residue", 128'(up_level), 128'(32));

      // Test 5: asynchronous reset mid-word
      up_clr = 1'b1;
      @(posedge clk); #1;
      up_clr = 1'b0;
      up_send(24'hABCDEF);
      up_send(24'h123456);
      up_send(24'h789ABC);
      check_val("t5_level", 128'(up_level), 128'(72));
      check_val("t5_partial", up_out_data, {72'hABCDEF123456789ABC, 56'h0});
      #2 rstn = 1'b0;
      #1;
      check_val("t5_rst_level", 128'(up_level), 128'(0));
      check_val("t5_rst_valid", 128'(up_out_valid), 128'(0));
      check_val("t5_rst_data", up_out_data, 128'(0));
      check_val("t5_rst_ready", 128'(up_in_ready), 128'(1));
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      up_send(24'hFFFFFF);
      check_val("t5_fresh", up_out_data, {24'hFFFFFF, 104'h0});
      check_val("t5_fresh_level", 128'(up_level), 128'(24));

      // Test 6: clr with simultaneous push and pop
      up_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) up_send(24'h00C0DE);
      check_val("t6_valid_pre", 128'(up_out_valid), 128'(1));
      up_q.delete();
      up_clr       = 1'b1;
      up_in_valid  = 1'b1;
      up_in_data   = 24'h5A5A5A;
      up_out_ready = 1'b1;
      @(posedge clk); #1;
      up_clr      = 1'b0;
      up_in_valid = 1'b0;
      up_in_data  = '0;
      check_val("t6_clr_level", 128'(up_level), 128'(0));
      check_val("t6_clr_valid", 128'(up_out_valid), 128'(0));
      check_val("t6_clr_data", up_out_data, 128'(0));
      up_send(24'h111111);
      up_send(24'h222222);
      up_send(24'h333333);
      up_send(24'h444444);
      up_send(24'h555555);
      up_send(24'h666666);
      idle(3);
      check_val("t6_count", 128'(up_q.size()), 128'(1));
      check_val("t6_w0", (up_q.size() > 0) ? up_q[0] : '0, 128'h11111122222233333344444455555566);
      check_val("t6_level", 128'(up_level), 128'(16));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_width_gearbox
